// File: rtl/vx_rop_dcr_ctrl.sv
// vx_rop_dcr_ctrl: ROP device configuration register block.
// Host writes land in a shadow copy; a COMMIT write copies the shadow into
// the active copy in one load, once the ROP pipeline reports idle.
// Optional read-back of the active copy is built when ROP_DCR_READ_EN is defined.

package rop_dcr_pkg;

  localparam logic [2:0] ROP_DEPTH_FUNC_ALWAYS = 3'd7;

  typedef struct packed {
    logic [31:0] cbuf_addr;
    logic [31:0] cbuf_pitch;
    logic [31:0] cbuf_mask;
    logic [31:0] zbuf_addr;
    logic [31:0] zbuf_pitch;
    logic [2:0]  depth_func;
    logic        depth_writemask;
    logic [2:0]  stencil_front_func;
    logic [2:0]  stencil_back_func;
    logic [2:0]  stencil_front_zpass;
    logic [2:0]  stencil_back_zpass;
    logic [2:0]  stencil_front_zfail;
    logic [2:0]  stencil_back_zfail;
    logic [2:0]  stencil_front_fail;
    logic [2:0]  stencil_back_fail;
    logic [7:0]  stencil_front_ref;
    logic [7:0]  stencil_back_ref;
    logic [7:0]  stencil_front_mask;
    logic [7:0]  stencil_back_mask;
    logic [7:0]  stencil_writemask;
    logic [2:0]  blend_mode_rgb;
    logic [2:0]  blend_mode_a;
    logic [3:0]  blend_src_rgb;
    logic [3:0]  blend_src_a;
    logic [3:0]  blend_dst_rgb;
    logic [3:0]  blend_dst_a;
    logic [31:0] blend_const;
    logic [3:0]  logic_op;
  } rop_dcrs_t;

  // Power-up configuration: everything passes, all channels writable.
  function automatic rop_dcrs_t rop_dcrs_reset();
    rop_dcrs_t s;
    s                    = '0;
    s.cbuf_mask          = 32'hFFFF_FFFF;
    s.stencil_front_mask = 8'hFF;
    s.stencil_back_mask  = 8'hFF;
    s.stencil_writemask  = 8'hFF;
    s.depth_func         = ROP_DEPTH_FUNC_ALWAYS;
    s.stencil_front_func = ROP_DEPTH_FUNC_ALWAYS;
    s.stencil_back_func  = ROP_DEPTH_FUNC_ALWAYS;
    return s;
  endfunction

endpackage

module vx_rop_dcr_ctrl
  import rop_dcr_pkg::*;
#(
  parameter int DCR_ADDR_BITS = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     dcr_wr_valid,
  input  logic [DCR_ADDR_BITS-1:0] dcr_wr_addr,
  input  logic [31:0]              dcr_wr_data,
  output logic                     dcr_wr_ready,
  input  logic                     dcr_rd_valid,
  input  logic [DCR_ADDR_BITS-1:0] dcr_rd_addr,
  output logic                     dcr_rd_ready,
  output logic                     dcr_rsp_valid,
  output logic [31:0]              dcr_rsp_data,
  input  logic                     dcr_rsp_ready,
  input  logic                     rop_idle,
  output rop_dcrs_t                rop_dcrs,
  output logic                     dcrs_updated
);

  localparam logic [DCR_ADDR_BITS-1:0] A_CBUF_ADDR  = DCR_ADDR_BITS'('h00);
  localparam logic [DCR_ADDR_BITS-1:0] A_CBUF_PITCH = DCR_ADDR_BITS'('h01);
  localparam logic [DCR_ADDR_BITS-1:0] A_CBUF_MASK  = DCR_ADDR_BITS'('h02);
  localparam logic [DCR_ADDR_BITS-1:0] A_ZBUF_ADDR  = DCR_ADDR_BITS'('h03);
  localparam logic [DCR_ADDR_BITS-1:0] A_ZBUF_PITCH = DCR_ADDR_BITS'('h04);
  localparam logic [DCR_ADDR_BITS-1:0] A_DEPTH_FUNC = DCR_ADDR_BITS'('h05);
  localparam logic [DCR_ADDR_BITS-1:0] A_DEPTH_WMSK = DCR_ADDR_BITS'('h06);
  localparam logic [DCR_ADDR_BITS-1:0] A_STN_FUNC   = DCR_ADDR_BITS'('h07);
  localparam logic [DCR_ADDR_BITS-1:0] A_STN_ZPASS  = DCR_ADDR_BITS'('h08);
  localparam logic [DCR_ADDR_BITS-1:0] A_STN_ZFAIL  = DCR_ADDR_BITS'('h09);
  localparam logic [DCR_ADDR_BITS-1:0] A_STN_FAIL   = DCR_ADDR_BITS'('h0A);
  localparam logic [DCR_ADDR_BITS-1:0] A_STN_REF    = DCR_ADDR_BITS'('h0B);
  localparam logic [DCR_ADDR_BITS-1:0] A_STN_MASK   = DCR_ADDR_BITS'('h0C);
  localparam logic [DCR_ADDR_BITS-1:0] A_STN_WMSK   = DCR_ADDR_BITS'('h0D);
  localparam logic [DCR_ADDR_BITS-1:0] A_BLEND_MODE = DCR_ADDR_BITS'('h0E);
  localparam logic [DCR_ADDR_BITS-1:0] A_BLEND_FUNC = DCR_ADDR_BITS'('h0F);
  localparam logic [DCR_ADDR_BITS-1:0] A_BLEND_CONST= DCR_ADDR_BITS'('h10);
  localparam logic [DCR_ADDR_BITS-1:0] A_LOGIC_OP   = DCR_ADDR_BITS'('h11);
  localparam logic [DCR_ADDR_BITS-1:0] A_COMMIT     = DCR_ADDR_BITS'('h12);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_APPLY = 2'd2
  } state_t;

  state_t    state_reg, state_next;
  rop_dcrs_t shadow_reg, shadow_next;
  rop_dcrs_t active_reg;
  logic      updated_reg;
  logic      wr_fire;

  // Merge one host write into a copy of the state; bits outside a field are dropped.
  function automatic rop_dcrs_t apply_write(rop_dcrs_t s_in,
                                            logic [DCR_ADDR_BITS-1:0] addr,
                                            logic [31:0] d);
    rop_dcrs_t s;
    s = s_in;
    case (addr)
      A_CBUF_ADDR:   s.cbuf_addr       = d;
      A_CBUF_PITCH:  s.cbuf_pitch      = d;
      A_CBUF_MASK:   s.cbuf_mask       = d;
      A_ZBUF_ADDR:   s.zbuf_addr       = d;
      A_ZBUF_PITCH:  s.zbuf_pitch      = d;
      A_DEPTH_FUNC:  s.depth_func      = d[2:0];
      A_DEPTH_WMSK:  s.depth_writemask = d[0];
      A_STN_FUNC: begin
        s.stencil_front_func = d[2:0];
        s.stencil_back_func  = d[18:16];
      end
      A_STN_ZPASS: begin
        s.stencil_front_zpass = d[2:0];
        s.stencil_back_zpass  = d[18:16];
      end
      A_STN_ZFAIL: begin
        s.stencil_front_zfail = d[2:0];
        s.stencil_back_zfail  = d[18:16];
      end
      A_STN_FAIL: begin
        s.stencil_front_fail = d[2:0];
        s.stencil_back_fail  = d[18:16];
      end
      A_STN_REF: begin
        s.stencil_front_ref = d[7:0];
        s.stencil_back_ref  = d[23:16];
      end
      A_STN_MASK: begin
        s.stencil_front_mask = d[7:0];
        s.stencil_back_mask  = d[23:16];
      end
      A_STN_WMSK:    s.stencil_writemask = d[7:0];
      A_BLEND_MODE: begin
        s.blend_mode_rgb = d[2:0];
        s.blend_mode_a   = d[18:16];
      end
      A_BLEND_FUNC: begin
        s.blend_src_rgb = d[3:0];
        s.blend_src_a   = d[11:8];
        s.blend_dst_rgb = d[19:16];
        s.blend_dst_a   = d[27:24];
      end
      A_BLEND_CONST: s.blend_const = d;
      A_LOGIC_OP:    s.logic_op    = d[3:0];
      default: ;
    endcase
    return s;
  endfunction

  assign wr_fire      = dcr_wr_valid && (state_reg == ST_IDLE);
  assign dcr_wr_ready = (state_reg == ST_IDLE);
  assign rop_dcrs     = active_reg;
  assign dcrs_updated = updated_reg;

  // Commit FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  // Commit FSM next state: wait for idle pipeline, then one apply cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (wr_fire && dcr_wr_addr == A_COMMIT) state_next = ST_PEND;
      ST_PEND:  if (rop_idle) state_next = ST_APPLY;
      ST_APPLY: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Shadow next value: accepted writes merge their field.
  always_comb begin
    shadow_next = shadow_reg;
    if (wr_fire) shadow_next = apply_write(shadow_reg, dcr_wr_addr, dcr_wr_data);
  end

  // Shadow/active copies; active loads the whole shadow in one edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_reg  <= rop_dcrs_reset();
      active_reg  <= rop_dcrs_reset();
      updated_reg <= 1'b0;
    end else begin
      shadow_reg  <= shadow_next;
      updated_reg <= (state_reg == ST_APPLY);
      if (state_reg == ST_APPLY) active_reg <= shadow_reg;
    end
  end

`ifdef ROP_DCR_READ_EN
  logic        rsp_valid_reg;
  logic [31:0] rsp_data_reg;
  logic        rd_fire;

  // Read-back of one register from a state copy, fields zero-extended in place.
  function automatic logic [31:0] read_back(rop_dcrs_t s, logic [DCR_ADDR_BITS-1:0] addr);
    logic [31:0] r;
    r = '0;
    case (addr)
      A_CBUF_ADDR:   r = s.cbuf_addr;
      A_CBUF_PITCH:  r = s.cbuf_pitch;
      A_CBUF_MASK:   r = s.cbuf_mask;
      A_ZBUF_ADDR:   r = s.zbuf_addr;
      A_ZBUF_PITCH:  r = s.zbuf_pitch;
      A_DEPTH_FUNC:  r = {29'b0, s.depth_func};
      A_DEPTH_WMSK:  r = {31'b0, s.depth_writemask};
      A_STN_FUNC:    r = {13'b0, s.stencil_back_func,  13'b0, s.stencil_front_func};
      A_STN_ZPASS:   r = {13'b0, s.stencil_back_zpass, 13'b0, s.stencil_front_zpass};
      A_STN_ZFAIL:   r = {13'b0, s.stencil_back_zfail, 13'b0, s.stencil_front_zfail};
      A_STN_FAIL:    r = {13'b0, s.stencil_back_fail,  13'b0, s.stencil_front_fail};
      A_STN_REF:     r = {8'b0, s.stencil_back_ref,  8'b0, s.stencil_front_ref};
      A_STN_MASK:    r = {8'b0, s.stencil_back_mask, 8'b0, s.stencil_front_mask};
      A_STN_WMSK:    r = {24'b0, s.stencil_writemask};
      A_BLEND_MODE:  r = {13'b0, s.blend_mode_a, 13'b0, s.blend_mode_rgb};
      A_BLEND_FUNC:  r = {4'b0, s.blend_dst_a, 4'b0, s.blend_dst_rgb,
                          4'b0, s.blend_src_a, 4'b0, s.blend_src_rgb};
      A_BLEND_CONST: r = s.blend_const;
      A_LOGIC_OP:    r = {28'b0, s.logic_op};
      default:       r = '0;
    endcase
    return r;
  endfunction

  assign dcr_rd_ready  = !rsp_valid_reg || dcr_rsp_ready;
  assign rd_fire       = dcr_rd_valid && dcr_rd_ready;
  assign dcr_rsp_valid = rsp_valid_reg;
  assign dcr_rsp_data  = rsp_data_reg;

  // Response register: captured from the active copy, held until taken.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
    end else if (rd_fire) begin
      rsp_valid_reg <= 1'b1;
      rsp_data_reg  <= read_back(active_reg, dcr_rd_addr);
    end else if (dcr_rsp_ready) begin
      rsp_valid_reg <= 1'b0;
    end
  end
`else
  // Read path absent: inputs are tied off and outputs held at zero.
  wire unused_rd = &{1'b0, dcr_rd_valid, dcr_rd_addr, dcr_rsp_ready};
  assign dcr_rd_ready  = 1'b0;
  assign dcr_rsp_valid = 1'b0;
  assign dcr_rsp_data  = '0;
`endif

endmodule
